// File: rtl/mult_seq16.sv
// Iterative 16x16 shift-and-add multiplier sequencer driving an external 4-bit step counter.
// Signed operands are handled by sign-magnitude correction around an unsigned core.
//
// state | meaning
// IDLE  | waiting for start; on start latch operands and clear the step counter
// RUN   | one add/shift iteration per cycle, iteration index taken from cnt
// DONE  | one-cycle ready pulse, product valid
module mult_seq16 #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [3:0]         cnt,
  output logic               cnt_en,
  output logic               cnt_clr,
  output logic               busy,
  output logic               ready,
  output logic [2*WIDTH-1:0] product
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [2*WIDTH-1:0] acc, acc_nxt, acc_step, product_nxt;
  logic [WIDTH-1:0]   m, m_nxt, mag_a, mag_b;
  logic [WIDTH:0]     upper_sum;
  logic               neg, neg_nxt, prod_ld;

  // 0x8000 negates to itself, which read as unsigned is the required 32768
  assign mag_a = (sgn && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
  assign mag_b = (sgn && multiplier[WIDTH-1])   ? -multiplier   : multiplier;

  assign upper_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
  assign acc_step    = {upper_sum, acc[WIDTH-1:1]};
  assign product_nxt = neg ? -acc_step : acc_step;

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    m_nxt     = m;
    neg_nxt   = neg;
    prod_ld   = 1'b0;
    cnt_en    = 1'b0;
    cnt_clr   = 1'b0;
    busy      = 1'b0;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          cnt_clr   = 1'b1;
          acc_nxt   = {{WIDTH{1'b0}}, mag_b};
          m_nxt     = mag_a;
          neg_nxt   = sgn & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        cnt_en  = 1'b1;
        acc_nxt = acc_step;
        // cnt is trusted; the clear issued on entry guarantees exactly 16 iterations
        if (cnt == 4'(WIDTH - 1)) begin
          prod_ld   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= IDLE;
      acc     <= '0;
      m       <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      m     <= m_nxt;
      neg   <= neg_nxt;
      if (prod_ld) product <= product_nxt;
    end
  end

endmodule

// File: tb/tb_mult_seq16.sv
// Self-checking bench for mult_seq16: vector table, directed corner sequences and
// randomized operands against an arithmetic reference model, with a behavioural step counter.
module tb_mult_seq16;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic        sgn;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic [3:0]  cnt = 4'd0;
  logic        cnt_en;
  logic        cnt_clr;
  logic        busy;
  logic        ready;
  logic [31:0] product;

  int total = 0;
  int bad   = 0;

  mult_seq16 dut (
    .clk          (clk),
    .clr          (clr),
    .start        (start),
    .sgn          (sgn),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .cnt          (cnt),
    .cnt_en       (cnt_en),
    .cnt_clr      (cnt_clr),
    .busy         (busy),
    .ready        (ready),
    .product      (product)
  );

  always #5 clk = ~clk;

  // external step counter: synchronous clear wins over enable, not reset by clr
  always @(posedge clk) begin
    if (cnt_clr)     cnt <= 4'd0;
    else if (cnt_en) cnt <= cnt + 4'd1;
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b, input logic s);
    longint x, y, p;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    p = x * y;
    return p[31:0];
  endfunction

  // One full operation. restart_at >= 0 pulses start (operands 2,2) when cnt equals it during RUN.
  task automatic run_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic [31:0] exp, input int restart_at);
    int busy_cnt, ready_cnt, ready_edge, overlap;
    logic [31:0] prod_at_ready;
    busy_cnt = 0; ready_cnt = 0; ready_edge = -1; overlap = 0; prod_at_ready = 32'hDEAD_BEEF;
    @(negedge clk);
    multiplicand = a; multiplier = b; sgn = s; start = 1'b1;
    #1;
    chk({nm, " cnt_clr_before_E0"}, 32'(cnt_clr), 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 24; k++) begin
      if (busy) busy_cnt++;
      if (cnt_en && cnt_clr) overlap++;
      if (ready) begin
        ready_cnt++;
        if (ready_edge < 0) begin
          ready_edge = k;
          prod_at_ready = product;
        end
      end
      if (restart_at >= 0 && busy && cnt == 4'(restart_at)) begin
        start = 1'b1; multiplicand = 16'h0002; multiplier = 16'h0002; sgn = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    chk({nm, " busy_cycles"}, 32'(busy_cnt), 32'd16);
    chk({nm, " ready_edge"}, 32'(ready_edge), 32'd16);
    chk({nm, " ready_pulses"}, 32'(ready_cnt), 32'd1);
    chk({nm, " en_clr_overlap"}, 32'(overlap), 32'd0);
    chk({nm, " product_at_ready"}, prod_at_ready, exp);
    chk({nm, " product_held"}, product, exp);
  endtask

  vec_t vecs[$];

  initial begin
    int waited, ready_seen;
    logic [15:0] ra, rb;
    logic        rs;

    vecs.push_back('{16'h0003, 16'h0005, 1'b0, 32'h0000000F});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001});
    vecs.push_back('{16'hFFFD, 16'h0007, 1'b1, 32'hFFFFFFEB});
    vecs.push_back('{16'h8000, 16'h8000, 1'b1, 32'h40000000});
    vecs.push_back('{16'h8000, 16'h0001, 1'b1, 32'hFFFF8000});
    vecs.push_back('{16'h1234, 16'h0000, 1'b1, 32'h00000000});
    vecs.push_back('{16'h8000, 16'h7FFF, 1'b1, 32'hC0008000});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001});
    vecs.push_back('{16'h0000, 16'h8000, 1'b1, 32'h00000000});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 32'h40000000});

    clr = 1'b0; start = 1'b0; sgn = 1'b0; multiplicand = '0; multiplier = '0;
    #12;
    chk("reset busy",    32'(busy),    32'd0);
    chk("reset ready",   32'(ready),   32'd0);
    chk("reset cnt_en",  32'(cnt_en),  32'd0);
    chk("reset cnt_clr", 32'(cnt_clr), 32'd0);
    chk("reset product", product,      32'd0);
    @(negedge clk); clr = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp, -1);

    // restart while running is ignored, then an accepted start works
    run_op("restart_ignored", 16'h0003, 16'h0005, 1'b0, 32'h0000000F, 5);
    run_op("after_restart", 16'h0002, 16'h0002, 1'b0, 32'h00000004, -1);

    // reset in the middle of RUN
    @(negedge clk);
    multiplicand = 16'h0003; multiplier = 16'h0005; sgn = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    waited = 0;
    while (!(busy && cnt == 4'd8) && waited < 40) begin
      @(posedge clk); #1; waited++;
    end
    chk("abort reached_cnt8", 32'(busy && cnt == 4'd8), 32'd1);
    clr = 1'b0;
    #1;
    chk("abort busy",    32'(busy),   32'd0);
    chk("abort ready",   32'(ready),  32'd0);
    chk("abort cnt_en",  32'(cnt_en), 32'd0);
    chk("abort product", product,     32'd0);
    ready_seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ready) ready_seen++;
    end
    @(negedge clk); clr = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (ready) ready_seen++;
    end
    chk("abort no_ready", 32'(ready_seen), 32'd0);
    run_op("after_abort", 16'h0010, 16'h0010, 1'b0, 32'h00000100, -1);

    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      if (i % 5 == 0) ra[15] = 1'b1;
      run_op($sformatf("rand%0d", i), ra, rb, rs, ref_mul(ra, rb, rs), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
